wb_line_fetcher: RTL and testbench
==================================

Name: wb_line_fetcher

Overview:
- Wishbone B4 master on the data-memory side, one stage upstream of the RAM slave.
- Converts cache-side requests into Wishbone cycles:
  - single-word read/write as a classic cycle;
  - full-line refill as a wrap-burst (critical word first).
- Returns read data beat by beat to the cache, flags the last beat, and reports bus errors or timeouts.

Parameters:
- LINE_WORDS, 4, words per cache line; legal values 4, 8, 16; maps to bte 01/10/11.
- TIMEOUT, 255, max cycles waiting for ack or err on one beat before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle (high only in IDLE).
- req_addr  in  32  byte address; bits [1:0] ignored.
- req_we  in  1  write (single only).
- req_line  in  1  line refill burst; ignored when req_we=1.
- req_wdata  in  32  write data.
- req_sel  in  4  byte enables for a single access.
- rsp_valid  out  1  one-cycle pulse per completed beat.
- rsp_data  out  32  read data of the beat.
- rsp_idx  out  log2(LINE_WORDS)  word index within the line.
- rsp_last  out  1  final response of the request.
- rsp_err  out  1  request ended on err or timeout.
- wbm_addr  out  32  Wishbone address, word aligned.
- wbm_dat_w  out  32  write data.
- wbm_sel  out  4  byte selects.
- wbm_cyc  out  1  cycle.
- wbm_stb  out  1  strobe.
- wbm_cti  out  3  cycle type.
- wbm_bte  out  2  burst type.
- wbm_we  out  1  write enable.
- wbm_dat_r  in  32  read data.
- wbm_ack  in  1  acknowledge.
- wbm_err  in  1  error.

Behaviour:
- Reset: all outputs 0; state IDLE; beat and timeout counters 0.
- IDLE:
  - req_ready=1.
  - On req_valid, register addr with [1:0]=0, plus wdata, sel and we.
  - Next cycle: cyc=stb=1.
  - Go to SINGLE if req_we=1 or req_line=0; otherwise BURST.
- SINGLE:
  - cti=000, bte=00, sel=req_sel.
  - Hold all outputs until ack or err.
  - On ack: drop cyc/stb the next cycle; rsp_valid=1, rsp_last=1, rsp_data=wbm_dat_r (reads; don't-care for writes), rsp_idx=addr word index; return to IDLE.
- BURST:
  - sel=1111, we=0, bte from LINE_WORDS.
  - cti=010 for beats 0..LINE_WORDS-2; cti=111 on the last beat. If LINE_WORDS==1 were legal it would be 111; it is not legal.
  - wbm_addr, cti and beat count are registered and advance only on a cycle with ack.
  - Next address: increment the word index modulo LINE_WORDS; keep the upper bits.
  - Example, LINE_WORDS=4, start 0x1C: beat addresses 0x1C, 0x10, 0x14, 0x18.
  - Each ack gives one rsp_valid pulse with rsp_idx = current word index.
  - Ack with cti=111 ends the burst: rsp_last=1, cyc/stb drop next cycle, return to IDLE.
  - No ack in a cycle: hold all outputs unchanged (slave wait state).
- err, in either state:
  - Drop cyc/stb the next cycle.
  - rsp_valid=1, rsp_last=1, rsp_err=1; return to IDLE.
  - Beats already returned stay valid.
- Timeout:
  - Counter clears on every ack and at cycle start; increments each cycle with stb=1 and no ack/err.
  - Reaching TIMEOUT behaves as err.
- Simultaneous ack and err: err wins; no data response for that beat.
- ack or err while cyc=0: ignored.
- Response latency: rsp_* registered, one cycle after the ack edge. Back-to-back requests therefore have at least 1 idle bus cycle between cycles.
- Reset mid-cycle: cyc/stb clear immediately (async); no response is issued.

Decomposition:
- Shared package wb_pkg holds:
  - CTI_CLASSIC=3'b000, CTI_CONST=3'b001, CTI_INCR=3'b010, CTI_END=3'b111;
  - BTE_LINEAR/WRAP4/WRAP8/WRAP16;
  - function bte_for_words(n);
  - state enum {IDLE, SINGLE, BURST}.
- The wrap next-address function lives in the package and is shared with the RAM model.
- No sub-module; a single FSM.

Test Plan:
- Single read of 0x100 (RAM word 0xDEADBEEF), classic slave: cti=000, one rsp with data 0xDEADBEEF, rsp_last=1, cyc low the cycle after ack.
- Single write 0x104, sel=0011, data 0x12345678: we=1, sel=0011; readback of 0x104 shows low half 0x5678 and upper bytes unchanged.
- LINE_WORDS=4 refill at 0x1C, ack every cycle: addresses 1C, 10, 14, 18; cti 010, 010, 010, 111; bte=01; rsp_idx 3, 0, 1, 2; rsp_last on 4th.
- LINE_WORDS=8 refill at 0x00 with slave stalling 2 cycles before beat 3: outputs held during stall, 8 responses in order 0..7, bte=10.
- err on beat 2 of a 4-word burst: 2 data responses, then rsp_err=1 with rsp_last=1; cyc=0 next cycle; FSM back in IDLE with req_ready=1.
- TIMEOUT=5, slave never acks: rsp_err=1 exactly 5 cycles after stb rises; assert rst mid-burst and check cyc=stb=0 immediately with no rsp_valid.

Source files
------------

// File: rtl/wb_pkg.sv
// Wishbone B4 cycle/burst encodings, fetcher state type and the
// wrap-burst address helper shared with the RAM model.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        SINGLE,
        BURST
    } state_t;

    function automatic logic [1:0] bte_for_words(input int unsigned n);
        logic [1:0] bte;
        case (n)
            4:       bte = BTE_WRAP4;
            8:       bte = BTE_WRAP8;
            16:      bte = BTE_WRAP16;
            default: bte = BTE_LINEAR;
        endcase
        return bte;
    endfunction

    // Step the word index modulo n, keeping all bits above the line.
    function automatic logic [31:0] wrap_next(
        input logic [31:0] addr,
        input int unsigned n
    );
        logic [31:0] mask;
        mask = 32'((n - 1) << 2);
        return (addr & ~mask) | ((addr + 32'd4) & mask);
    endfunction

endpackage

// File: rtl/wb_line_fetcher.sv
// Wishbone B4 master: single classic accesses and critical-word-first
// wrap-burst line refills, with per-beat responses and err/timeout abort.
module wb_line_fetcher
    import wb_pkg::*;
#(
    parameter int LINE_WORDS = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [31:0]                   req_addr,
    input  logic                          req_we,
    input  logic                          req_line,
    input  logic [31:0]                   req_wdata,
    input  logic [3:0]                    req_sel,
    output logic                          rsp_valid,
    output logic [31:0]                   rsp_data,
    output logic [$clog2(LINE_WORDS)-1:0] rsp_idx,
    output logic                          rsp_last,
    output logic                          rsp_err,
    output logic [31:0]                   wbm_addr,
    output logic [31:0]                   wbm_dat_w,
    output logic [3:0]                    wbm_sel,
    output logic                          wbm_cyc,
    output logic                          wbm_stb,
    output logic [2:0]                    wbm_cti,
    output logic [1:0]                    wbm_bte,
    output logic                          wbm_we,
    input  logic [31:0]                   wbm_dat_r,
    input  logic                          wbm_ack,
    input  logic                          wbm_err
);

    localparam int IW = $clog2(LINE_WORDS);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] LAST = IW'(LINE_WORDS - 1);

    state_t state;
    state_t state_nxt;

    logic [IW-1:0] beat;
    logic [IW-1:0] beat_nxt;
    logic [TW-1:0] tmo;
    logic [TW-1:0] tmo_nxt;

    logic [31:0] addr_nxt;
    logic [31:0] dat_w_nxt;
    logic [3:0]  sel_nxt;
    logic        we_nxt;
    logic [2:0]  cti_nxt;
    logic [1:0]  bte_nxt;
    logic        cyc_nxt;
    logic        stb_nxt;

    logic          rsp_valid_nxt;
    logic [31:0]   rsp_data_nxt;
    logic [IW-1:0] rsp_idx_nxt;
    logic          rsp_last_nxt;
    logic          rsp_err_nxt;

    logic          done;
    logic          tmo_hit;
    logic [IW-1:0] word_idx;
    logic          unused_bits;

    assign unused_bits = ^req_addr[1:0];
    assign word_idx    = wbm_addr[IW+1:2];
    assign req_ready   = (state == IDLE) && !rst;

    // An ack on the same edge rescues the beat from the timeout.
    assign tmo_hit = (TIMEOUT != 0) && wbm_stb && !wbm_ack &&
                     (32'(tmo) == 32'(TIMEOUT - 1));

    always_comb begin
        state_nxt     = state;
        addr_nxt      = wbm_addr;
        dat_w_nxt     = wbm_dat_w;
        sel_nxt       = wbm_sel;
        we_nxt        = wbm_we;
        cti_nxt       = wbm_cti;
        bte_nxt       = wbm_bte;
        cyc_nxt       = wbm_cyc;
        stb_nxt       = wbm_stb;
        beat_nxt      = beat;
        tmo_nxt       = tmo;
        rsp_valid_nxt = 1'b0;
        rsp_data_nxt  = rsp_data;
        rsp_idx_nxt   = rsp_idx;
        rsp_last_nxt  = 1'b0;
        rsp_err_nxt   = 1'b0;
        done          = 1'b0;

        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    addr_nxt  = {req_addr[31:2], 2'b00};
                    dat_w_nxt = req_wdata;
                    cyc_nxt   = 1'b1;
                    stb_nxt   = 1'b1;
                    beat_nxt  = '0;
                    tmo_nxt   = '0;
                    if (req_we || !req_line) begin
                        state_nxt = SINGLE;
                        sel_nxt   = req_sel;
                        we_nxt    = req_we;
                        cti_nxt   = CTI_CLASSIC;
                        bte_nxt   = BTE_LINEAR;
                    end else begin
                        state_nxt = BURST;
                        sel_nxt   = 4'hF;
                        we_nxt    = 1'b0;
                        bte_nxt   = bte_for_words(LINE_WORDS);
                        cti_nxt   = (LINE_WORDS == 1) ? CTI_END : CTI_INCR;
                    end
                end
            end
            SINGLE, BURST: begin
                if (wbm_err || tmo_hit) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_last_nxt  = 1'b1;
                    rsp_err_nxt   = 1'b1;
                    done          = 1'b1;
                end else if (wbm_ack) begin
                    rsp_valid_nxt = 1'b1;
                    rsp_data_nxt  = wbm_dat_r;
                    rsp_idx_nxt   = word_idx;
                    tmo_nxt       = '0;
                    if (state == SINGLE || wbm_cti == CTI_END) begin
                        rsp_last_nxt = 1'b1;
                        done         = 1'b1;
                    end else begin
                        addr_nxt = wrap_next(wbm_addr, LINE_WORDS);
                        beat_nxt = beat + 1'b1;
                        cti_nxt  = (beat_nxt == LAST) ? CTI_END : CTI_INCR;
                    end
                end else if (TIMEOUT != 0) begin
                    tmo_nxt = tmo + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (done) begin
            state_nxt = IDLE;
            addr_nxt  = '0;
            dat_w_nxt = '0;
            sel_nxt   = '0;
            we_nxt    = 1'b0;
            cti_nxt   = CTI_CLASSIC;
            bte_nxt   = BTE_LINEAR;
            cyc_nxt   = 1'b0;
            stb_nxt   = 1'b0;
            beat_nxt  = '0;
            tmo_nxt   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wbm_addr  <= '0;
            wbm_dat_w <= '0;
            wbm_sel   <= '0;
            wbm_we    <= 1'b0;
            wbm_cti   <= CTI_CLASSIC;
            wbm_bte   <= BTE_LINEAR;
            wbm_cyc   <= 1'b0;
            wbm_stb   <= 1'b0;
            beat      <= '0;
            tmo       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_idx   <= '0;
            rsp_last  <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            wbm_addr  <= addr_nxt;
            wbm_dat_w <= dat_w_nxt;
            wbm_sel   <= sel_nxt;
            wbm_we    <= we_nxt;
            wbm_cti   <= cti_nxt;
            wbm_bte   <= bte_nxt;
            wbm_cyc   <= cyc_nxt;
            wbm_stb   <= stb_nxt;
            beat      <= beat_nxt;
            tmo       <= tmo_nxt;
            rsp_valid <= rsp_valid_nxt;
            rsp_data  <= rsp_data_nxt;
            rsp_idx   <= rsp_idx_nxt;
            rsp_last  <= rsp_last_nxt;
            rsp_err   <= rsp_err_nxt;
        end
    end

endmodule

// File: tb/tb_wb_line_fetcher.sv
// Bench for wb_line_fetcher: a 4-word (TIMEOUT=5) and an 8-word (no timeout)
// instance share one scripted Wishbone RAM slave and a beat-level reference model.
module tb_wb_line_fetcher;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        use8 = 1'b0;
    logic        req_valid, req_we, req_line;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_sel;
    logic        ack, err;
    logic [31:0] dat_r;

    logic        rdy4, rv4, rl4, re4, cyc4, stb4, we4;
    logic [31:0] rd4, a4, dw4;
    logic [1:0]  ri4, bte4;
    logic [3:0]  sel4;
    logic [2:0]  cti4;

    logic        rdy8, rv8, rl8, re8, cyc8, stb8, we8;
    logic [31:0] rd8, a8, dw8;
    logic [2:0]  ri8, cti8;
    logic [1:0]  bte8;
    logic [3:0]  sel8;

    wb_line_fetcher #(.LINE_WORDS(4), .TIMEOUT(5)) u4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & ~use8), .req_ready(rdy4),
        .req_addr(req_addr), .req_we(req_we), .req_line(req_line),
        .req_wdata(req_wdata), .req_sel(req_sel),
        .rsp_valid(rv4), .rsp_data(rd4), .rsp_idx(ri4),
        .rsp_last(rl4), .rsp_err(re4),
        .wbm_addr(a4), .wbm_dat_w(dw4), .wbm_sel(sel4),
        .wbm_cyc(cyc4), .wbm_stb(stb4), .wbm_cti(cti4),
        .wbm_bte(bte4), .wbm_we(we4), .wbm_dat_r(dat_r),
        .wbm_ack(ack & ~use8), .wbm_err(err & ~use8)
    );

    wb_line_fetcher #(.LINE_WORDS(8), .TIMEOUT(0)) u8 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & use8), .req_ready(rdy8),
        .req_addr(req_addr), .req_we(req_we), .req_line(req_line),
        .req_wdata(req_wdata), .req_sel(req_sel),
        .rsp_valid(rv8), .rsp_data(rd8), .rsp_idx(ri8),
        .rsp_last(rl8), .rsp_err(re8),
        .wbm_addr(a8), .wbm_dat_w(dw8), .wbm_sel(sel8),
        .wbm_cyc(cyc8), .wbm_stb(stb8), .wbm_cti(cti8),
        .wbm_bte(bte8), .wbm_we(we8), .wbm_dat_r(dat_r),
        .wbm_ack(ack & use8), .wbm_err(err & use8)
    );

    wire        o_ready = use8 ? rdy8 : rdy4;
    wire        o_rv    = use8 ? rv8 : rv4;
    wire        o_last  = use8 ? rl8 : rl4;
    wire        o_err   = use8 ? re8 : re4;
    wire        o_cyc   = use8 ? cyc8 : cyc4;
    wire        o_stb   = use8 ? stb8 : stb4;
    wire        o_we    = use8 ? we8 : we4;
    wire [31:0] o_data  = use8 ? rd8 : rd4;
    wire [31:0] o_addr  = use8 ? a8 : a4;
    wire [31:0] o_dw    = use8 ? dw8 : dw4;
    wire [3:0]  o_idx   = use8 ? {1'b0, ri8} : {2'b00, ri4};
    wire [3:0]  o_sel   = use8 ? sel8 : sel4;
    wire [2:0]  o_cti   = use8 ? cti8 : cti4;
    wire [1:0]  o_bte   = use8 ? bte8 : bte4;

    logic [31:0] mem [256];
    logic [31:0] got_rdata;
    int vectors = 0;
    int miscompares = 0;

    // One request end to end; slave stalls/errs as scripted, model predicts every beat.
    task automatic do_req(input bit w8, input logic [31:0] a, input bit we,
                          input bit line, input logic [3:0] sel, input logic [31:0] wd,
                          input int stall_max, input int fix_beat, input int fix_len,
                          input int err_beat);
        int nl, n, start, k, stall, guard;
        bit burst, fin, pv, pl, pe;
        logic [31:0] base, ea, pd;
        logic [3:0] pi, esel;
        logic [2:0] ecti;
        logic [1:0] ebte;
        logic [7:0] widx;
        nl    = w8 ? 8 : 4;
        burst = line && !we;
        n     = burst ? nl : 1;
        start = int'((a >> 2) % nl);
        base  = a & ~(32'(nl * 4 - 1));
        use8 = w8; req_valid = 1'b1; req_addr = a; req_we = we;
        req_line = line; req_sel = sel; req_wdata = wd;
        vectors++;
        if (o_ready !== 1'b1) begin
            miscompares++; $display("FAIL req_ready: got %b want 1", o_ready);
        end
        @(negedge clk);
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        k = 0; fin = 0; pv = 0; pl = 0; pe = 0; pd = '0; pi = '0; guard = 0;
        stall = (fix_beat == 0) ? fix_len : int'($urandom_range(0, stall_max));
        forever begin
            vectors++;
            if (o_rv !== pv) begin
                miscompares++; $display("FAIL rsp_valid: got %b want %b", o_rv, pv);
            end
            if (pv) begin
                vectors++;
                if ({o_last, o_err} !== {pl, pe}) begin
                    miscompares++;
                    $display("FAIL rsp_last/err: got %b%b want %b%b", o_last, o_err, pl, pe);
                end
                if (!pe) begin
                    vectors++;
                    if (o_idx !== pi) begin
                        miscompares++; $display("FAIL rsp_idx: got %0d want %0d", o_idx, pi);
                    end
                    if (!we) begin
                        got_rdata = o_data;
                        vectors++;
                        if (o_data !== pd) begin
                            miscompares++; $display("FAIL rsp_data: got %h want %h", o_data, pd);
                        end
                    end
                end
            end
            ack = 1'b0; err = 1'b0; pv = 0;
            if (fin) begin
                vectors++;
                if ({o_cyc, o_stb, o_ready} !== 3'b001) begin
                    miscompares++;
                    $display("FAIL end_of_cycle: got cyc/stb/ready %b%b%b want 001",
                             o_cyc, o_stb, o_ready);
                end
                break;
            end
            if (guard++ > 200) begin
                vectors++; miscompares++;
                $display("FAIL cycle_budget: got beat %0d want %0d", k, n);
                break;
            end
            ea   = burst ? base + 32'(((start + k) % nl) * 4) : {a[31:2], 2'b00};
            ecti = !burst ? 3'b000 : (k == n - 1) ? 3'b111 : 3'b010;
            ebte = !burst ? 2'b00 : (w8 ? 2'b10 : 2'b01);
            esel = burst ? 4'hF : sel;
            vectors++;
            if (o_addr !== ea) begin
                miscompares++; $display("FAIL wbm_addr: got %h want %h", o_addr, ea);
            end
            vectors++;
            if ({o_cyc, o_stb, o_we, o_cti, o_bte, o_sel, o_ready} !==
                {2'b11, we, ecti, ebte, esel, 1'b0}) begin
                miscompares++;
                $display("FAIL bus_ctl: got cyc%b stb%b we%b cti%b bte%b sel%b rdy%b want we%b cti%b bte%b sel%b",
                         o_cyc, o_stb, o_we, o_cti, o_bte, o_sel, o_ready, we, ecti, ebte, esel);
            end
            if (we) begin
                vectors++;
                if (o_dw !== wd) begin
                    miscompares++; $display("FAIL wbm_dat_w: got %h want %h", o_dw, wd);
                end
            end
            widx = ea[9:2];
            if (stall > 0) begin
                stall--; dat_r = $urandom;
            end else if (k == err_beat) begin
                err = 1'b1; ack = 1'($urandom_range(0, 1)); dat_r = $urandom;
                pv = 1; pl = 1; pe = 1; fin = 1;
            end else begin
                ack = 1'b1;
                if (we) begin
                    dat_r = $urandom;
                    for (int b = 0; b < 4; b++)
                        if (o_sel[b]) mem[widx][8*b +: 8] = o_dw[8*b +: 8];
                end else begin
                    dat_r = mem[widx]; pd = mem[widx];
                end
                pv = 1; pl = (k == n - 1); pe = 0;
                pi = burst ? 4'((start + k) % nl) : 4'(start);
                k++;
                if (k == n) fin = 1;
                stall = (k == fix_beat) ? fix_len : int'($urandom_range(0, stall_max));
            end
            @(negedge clk);
        end
        ack = 1'b0; err = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 0; req_we = 0; req_line = 0;
        req_addr = 0; req_wdata = 0; req_sel = 0; ack = 0; err = 0; dat_r = 0;
        #1;
        vectors++;
        if ({rv4, rl4, re4, cyc4, stb4, we4, rd4, a4, dw4, ri4, sel4, cti4, bte4, rdy4} !== '0) begin
            miscompares++; $display("FAIL reset_u4: got outputs non-zero want 0");
        end
        vectors++;
        if ({rv8, rl8, re8, cyc8, stb8, we8, rd8, a8, dw8, ri8, sel8, cti8, bte8, rdy8} !== '0) begin
            miscompares++; $display("FAIL reset_u8: got outputs non-zero want 0");
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({rdy4, rdy8, cyc4, cyc8} !== 4'b1100) begin
            miscompares++;
            $display("FAIL ready_after_reset: got %b want 1100", {rdy4, rdy8, cyc4, cyc8});
        end
    endtask

    task automatic test_idle_ignore();
        use8 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ack = 1'b1; err = 1'($urandom_range(0, 1)); dat_r = $urandom;
            @(negedge clk);
            vectors++;
            if ({rv4, cyc4, rdy4} !== 3'b001) begin
                miscompares++;
                $display("FAIL idle_ignore: got rv/cyc/rdy %b%b%b want 001", rv4, cyc4, rdy4);
            end
        end
        ack = 1'b0; err = 1'b0;
    endtask

    task automatic test_single();
        mem[8'h40] = 32'hDEADBEEF;
        do_req(0, 32'h100, 0, 0, 4'hF, 32'h0, 0, -1, 0, -1);
        vectors++;
        if (got_rdata !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL single_read: got %h want deadbeef", got_rdata);
        end
        mem[8'h41] = 32'hAABBCCDD;
        do_req(0, 32'h104, 1, 1, 4'b0011, 32'h12345678, 0, -1, 0, -1);
        do_req(0, 32'h106, 0, 0, 4'hF, 32'h0, 0, -1, 0, -1);
        vectors++;
        if (got_rdata !== 32'hAABB5678) begin
            miscompares++; $display("FAIL write_readback: got %h want aabb5678", got_rdata);
        end
    endtask

    task automatic test_bursts();
        do_req(0, 32'h1C, 0, 1, 4'h0, 32'h0, 0, -1, 0, -1);
        do_req(1, 32'h00, 0, 1, 4'h0, 32'h0, 0, 3, 2, -1);
        do_req(0, 32'h84, 0, 1, 4'h0, 32'h0, 0, 1, 4, -1);
    endtask

    task automatic test_burst_err();
        do_req(0, 32'h20, 0, 1, 4'h0, 32'h0, 0, -1, 0, 2);
        do_req(1, 32'h3E8, 0, 1, 4'h0, 32'h0, 1, -1, 0, 5);
    endtask

    task automatic test_timeout();
        use8 = 1'b0; req_valid = 1'b1; req_addr = 32'h80; req_we = 0; req_line = 1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({cyc4, stb4, rv4} !== 3'b110) begin
                miscompares++;
                $display("FAIL timeout_wait %0d: got cyc/stb/rv %b%b%b want 110", i, cyc4, stb4, rv4);
            end
            @(negedge clk);
        end
        vectors++;
        if ({rv4, re4, rl4, cyc4, stb4} !== 5'b11100) begin
            miscompares++;
            $display("FAIL timeout_fire: got rv/err/last/cyc/stb %b want 11100",
                     {rv4, re4, rl4, cyc4, stb4});
        end
    endtask

    task automatic test_reset_mid();
        use8 = 1'b0; req_valid = 1'b1; req_addr = 32'h44; req_we = 0; req_line = 1;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ack = 1'b1; dat_r = $urandom;
            @(negedge clk);
        end
        ack = 1'b0;
        rst = 1'b1;
        #1;
        vectors++;
        if ({cyc4, stb4, rv4, rdy4} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_mid: got cyc/stb/rv/rdy %b want 0000", {cyc4, stb4, rv4, rdy4});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if ({cyc4, rv4, rdy4} !== 3'b001) begin
            miscompares++;
            $display("FAIL after_reset_mid: got cyc/rv/rdy %b want 001", {cyc4, rv4, rdy4});
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_req(1'($urandom_range(0, 1)), $urandom & 32'h3FF,
                   ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)),
                   4'($urandom_range(1, 15)), $urandom, 3, -1, 0,
                   ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 7)) : -1);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++)
            do_req(0, 32'(i * 16 + 8), 0, 1, 4'h0, 32'h0, 0, -1, 0, -1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        test_reset();
        test_idle_ignore();
        test_single();
        test_bursts();
        test_burst_err();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
